// File: rtl/axi_lite_write_sequencer.sv
// Buffers AXI-Stream address/data beats in a small FIFO and replays them one at a
// time as single-cycle write strobes into an AXI-Lite master core, paced on its busy flag.
module axi_lite_write_sequencer #(
    parameter int AXI_DATA_WIDTH  = 32,
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                                     aclk,
    input  logic                                     aresetn,
    input  logic [AXI_ADDR_WIDTH+AXI_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                                     s_axis_tvalid,
    output logic                                     s_axis_tready,
    input  logic                                     enable_i,
    output logic [AXI_ADDR_WIDTH-1:0]                waddr_o,
    output logic [AXI_DATA_WIDTH-1:0]                wdata_o,
    output logic [AXI_DATA_WIDTH/8-1:0]              wstrb_o,
    output logic                                     write_o,
    input  logic                                     busy_i,
    input  logic                                     write_failure_i,
    output logic [FIFO_DEPTH_LOG2:0]                 fifo_count_o,
    output logic                                     idle_o,
    output logic [31:0]                              sent_count_o,
    output logic [15:0]                              fail_count_o
);

    localparam int CMD_W = AXI_ADDR_WIDTH + AXI_DATA_WIDTH;
    localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0] FULL_COUNT = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [FIFO_DEPTH_LOG2:0] ONE_COUNT  = (FIFO_DEPTH_LOG2 + 1)'(1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE      = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [CMD_W-1:0]           mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]   count;
    logic                       full, empty, push, pop, done;
    logic [31:0]                sent_count_q;
    logic [15:0]                fail_count_q;

    assign full          = (count == FULL_COUNT);
    assign empty         = (count == '0);
    assign s_axis_tready = !full;
    assign push          = s_axis_tvalid && !full;
    assign done          = (state == WAIT_DONE) && !busy_i;

    // Buffer storage has no reset; discarding beats only needs the pointers cleared.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr] <= s_axis_tdata;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + ONE_COUNT;
                2'b01:   count <= count - ONE_COUNT;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= IDLE;
            waddr_o <= '0;
            wdata_o <= '0;
        end else begin
            state <= state_nxt;
            if (pop) begin
                waddr_o <= mem[rd_ptr][CMD_W-1:AXI_DATA_WIDTH];
                wdata_o <= mem[rd_ptr][AXI_DATA_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        write_o   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && enable_i && !busy_i) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                write_o   = 1'b1;
                state_nxt = WAIT_START;
            end
            WAIT_START: begin
                if (busy_i) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!busy_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The failure flag is only meaningful on the cycle busy falls.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sent_count_q <= '0;
            fail_count_q <= '0;
        end else if (done) begin
            sent_count_q <= sent_count_q + 32'd1;
            if (write_failure_i && (fail_count_q != 16'hFFFF)) begin
                fail_count_q <= fail_count_q + 16'd1;
            end
        end
    end

    assign wstrb_o      = '1;
    assign fifo_count_o = count;
    assign idle_o       = (state == IDLE) && empty;
    assign sent_count_o = sent_count_q;
    assign fail_count_o = fail_count_q;

endmodule

// File: tb/tb_axi_lite_write_sequencer.sv
// Directed bench for axi_lite_write_sequencer: a vector table for the FIFO fill,
// hand-written sequences for drain, failures, push/pop at depth 15 and reset mid-write.
module tb_axi_lite_write_sequencer;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [63:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        enable_i = 1'b0;
    logic [31:0] waddr_o;
    logic [31:0] wdata_o;
    logic [3:0]  wstrb_o;
    logic        write_o;
    logic        busy_i = 1'b0;
    logic        write_failure_i = 1'b0;
    logic [4:0]  fifo_count_o;
    logic        idle_o;
    logic [31:0] sent_count_o;
    logic [15:0] fail_count_o;

    axi_lite_write_sequencer #(
        .AXI_DATA_WIDTH (32),
        .AXI_ADDR_WIDTH (32),
        .FIFO_DEPTH_LOG2(4)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .enable_i       (enable_i),
        .waddr_o        (waddr_o),
        .wdata_o        (wdata_o),
        .wstrb_o        (wstrb_o),
        .write_o        (write_o),
        .busy_i         (busy_i),
        .write_failure_i(write_failure_i),
        .fifo_count_o   (fifo_count_o),
        .idle_o         (idle_o),
        .sent_count_o   (sent_count_o),
        .fail_count_o   (fail_count_o)
    );

    always #5 aclk = ~aclk;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        logic        tvalid;
        logic [63:0] tdata;
        logic        enable;
        logic        exp_ready;
        logic [4:0]  exp_count;
    } vec_t;

    vec_t fill_tab[17];

    // Master-core model state
    int          busy_len = 3;
    int          fail_sel = -1;
    logic        fail_all = 1'b0;
    logic        fail_now = 1'b0;
    logic        master_active = 1'b0;
    int          pulse_cnt = 0;
    logic [63:0] seen_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] beat(input int i);
        return {32'h4000_1000 + 32'(i * 4), 32'hC0DE_0000 + 32'(i)};
    endfunction

    // Responds to each write pulse: busy rises one cycle later, stays high busy_len
    // cycles, and the failure flag is presented on the cycle busy falls.
    always begin
        @(negedge aclk);
        if (write_o === 1'b1) begin
            master_active = 1'b1;
            check("no_write_while_busy", 64'(busy_i), 64'd0);
            check("wstrb_all_ones", 64'(wstrb_o), 64'hF);
            seen_q.push_back({waddr_o, wdata_o});
            pulse_cnt++;
            fail_now = fail_all || (pulse_cnt == fail_sel);
            @(negedge aclk);
            check("write_single_cycle", 64'(write_o), 64'd0);
            busy_i = 1'b1;
            repeat (busy_len) @(negedge aclk);
            busy_i = 1'b0;
            write_failure_i = fail_now;
            @(negedge aclk);
            write_failure_i = 1'b0;
            master_active = 1'b0;
        end
    end

    task automatic push(input logic [63:0] d);
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_quiet(input string name, input int budget);
        int n = 0;
        while (!(idle_o && !master_active && !busy_i) && n < budget) begin
            @(negedge aclk);
            n++;
        end
        if (n >= budget) begin
            check({name, "_timeout"}, 64'(n), 64'(budget - 1));
        end
    endtask

    task automatic do_reset();
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        enable_i      = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        seen_q.delete();
        pulse_cnt = 0;
        fail_sel  = -1;
        fail_all  = 1'b0;
        @(negedge aclk);
    endtask

    initial begin
        for (int i = 0; i < 17; i++) begin
            fill_tab[i].tvalid    = 1'b1;
            fill_tab[i].tdata     = beat(i);
            fill_tab[i].enable    = 1'b0;
            fill_tab[i].exp_ready = (i < 16);
            fill_tab[i].exp_count = (i < 16) ? 5'(i) : 5'd16;
        end

        // Reset values
        @(negedge aclk);
        check("rst_tready", 64'(s_axis_tready), 64'd1);
        check("rst_write", 64'(write_o), 64'd0);
        check("rst_waddr", 64'(waddr_o), 64'd0);
        check("rst_wdata", 64'(wdata_o), 64'd0);
        check("rst_wstrb", 64'(wstrb_o), 64'hF);
        check("rst_count", 64'(fifo_count_o), 64'd0);
        check("rst_idle", 64'(idle_o), 64'd1);
        check("rst_sent", 64'(sent_count_o), 64'd0);
        check("rst_fail", 64'(fail_count_o), 64'd0);
        aresetn = 1'b1;
        @(negedge aclk);

        // Single write: pop one edge after the push, pulse in the following cycle
        busy_len = 3;
        enable_i = 1'b1;
        push({32'h4000_0010, 32'hDEAD_BEEF});
        check("single_write_not_yet", 64'(write_o), 64'd0);
        check("single_count_1", 64'(fifo_count_o), 64'd1);
        @(negedge aclk);
        check("single_write_pulse", 64'(write_o), 64'd1);
        check("single_waddr", 64'(waddr_o), 64'h4000_0010);
        check("single_wdata", 64'(wdata_o), 64'hDEAD_BEEF);
        check("single_count_0", 64'(fifo_count_o), 64'd0);
        wait_quiet("single", 50);
        check("single_sent", 64'(sent_count_o), 64'd1);
        check("single_fail", 64'(fail_count_o), 64'd0);
        check("single_idle", 64'(idle_o), 64'd1);
        check("single_pulses", 64'(pulse_cnt), 64'd1);
        check("single_addr_held", 64'(waddr_o), 64'h4000_0010);

        // Fill with enable low, table-driven
        do_reset();
        for (int i = 0; i < 17; i++) begin
            check($sformatf("fill_ready_%0d", i), 64'(s_axis_tready), 64'(fill_tab[i].exp_ready));
            check($sformatf("fill_count_%0d", i), 64'(fifo_count_o), 64'(fill_tab[i].exp_count));
            check($sformatf("fill_nowrite_%0d", i), 64'(write_o), 64'd0);
            s_axis_tdata  = fill_tab[i].tdata;
            s_axis_tvalid = fill_tab[i].tvalid;
            enable_i      = fill_tab[i].enable;
            @(negedge aclk);
        end
        s_axis_tvalid = 1'b0;
        check("fill_final_count", 64'(fifo_count_o), 64'd16);
        check("fill_final_ready", 64'(s_axis_tready), 64'd0);
        check("fill_no_pulses", 64'(pulse_cnt), 64'd0);

        // Drain
        busy_len = 2;
        enable_i = 1'b1;
        @(negedge aclk);
        wait_quiet("drain", 400);
        check("drain_pulses", 64'(pulse_cnt), 64'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < seen_q.size()) check($sformatf("drain_order_%0d", i), seen_q[i], beat(i));
        end
        check("drain_sent", 64'(sent_count_o), 64'd16);
        check("drain_count", 64'(fifo_count_o), 64'd0);

        // Failure counting: 2nd write fails
        do_reset();
        fail_sel = 2;
        busy_len = 1;
        enable_i = 1'b1;
        for (int i = 0; i < 3; i++) push(beat(i));
        wait_quiet("fail3", 200);
        check("fail3_sent", 64'(sent_count_o), 64'd3);
        check("fail3_fail", 64'(fail_count_o), 64'd1);

        // Saturation: preload near the top, then two more failures
        fail_sel = -1;
        fail_all = 1'b1;
        force dut.fail_count_q = 16'hFFFE;
        #1;
        release dut.fail_count_q;
        push(beat(7));
        wait_quiet("sat1", 100);
        check("sat_reach_ffff", 64'(fail_count_o), 64'hFFFF);
        push(beat(8));
        wait_quiet("sat2", 100);
        check("sat_hold_ffff", 64'(fail_count_o), 64'hFFFF);
        check("sat_sent", 64'(sent_count_o), 64'd5);
        fail_all = 1'b0;

        // Simultaneous push and pop at 15 entries
        do_reset();
        busy_len = 1;
        for (int i = 0; i < 15; i++) push(beat(i));
        check("pp_count_15", 64'(fifo_count_o), 64'd15);
        enable_i      = 1'b1;
        s_axis_tdata  = beat(15);
        s_axis_tvalid = 1'b1;
        @(negedge aclk);
        enable_i      = 1'b0;
        check("pp_count_same", 64'(fifo_count_o), 64'd15);
        s_axis_tdata  = beat(16);
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        check("pp_count_16", 64'(fifo_count_o), 64'd16);
        check("pp_ready_low", 64'(s_axis_tready), 64'd0);
        enable_i = 1'b1;
        @(negedge aclk);
        wait_quiet("pp_drain", 400);
        check("pp_pulses", 64'(pulse_cnt), 64'd17);
        for (int i = 0; i < 17; i++) begin
            if (i < seen_q.size()) check($sformatf("pp_order_%0d", i), seen_q[i], beat(i));
        end

        // Reset mid-write with 5 entries buffered
        do_reset();
        busy_len = 6;
        for (int i = 0; i < 6; i++) push(beat(20 + i));
        enable_i = 1'b1;
        begin
            int n = 0;
            while (!busy_i && n < 50) begin
                @(negedge aclk);
                n++;
            end
            if (n >= 50) check("midrst_busy_timeout", 64'(n), 64'd49);
        end
        @(negedge aclk);
        check("midrst_count_5", 64'(fifo_count_o), 64'd5);
        #2;
        aresetn = 1'b0;
        #1;
        check("midrst_tready", 64'(s_axis_tready), 64'd1);
        check("midrst_write", 64'(write_o), 64'd0);
        check("midrst_waddr", 64'(waddr_o), 64'd0);
        check("midrst_wdata", 64'(wdata_o), 64'd0);
        check("midrst_count", 64'(fifo_count_o), 64'd0);
        check("midrst_idle", 64'(idle_o), 64'd1);
        check("midrst_sent", 64'(sent_count_o), 64'd0);
        begin
            int n = 0;
            while (master_active && n < 50) begin
                @(negedge aclk);
                n++;
            end
            if (n >= 50) check("midrst_master_timeout", 64'(n), 64'd49);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        seen_q.delete();
        pulse_cnt = 0;
        busy_len  = 2;
        repeat (3) @(negedge aclk);
        check("midrst_no_stale_pulse", 64'(pulse_cnt), 64'd0);
        check("midrst_idle_after", 64'(idle_o), 64'd1);
        push({32'h4000_0020, 32'h1234_5678});
        wait_quiet("midrst_new", 50);
        check("midrst_new_pulses", 64'(pulse_cnt), 64'd1);
        if (seen_q.size() > 0) check("midrst_new_beat", seen_q[0], {32'h4000_0020, 32'h1234_5678});
        check("midrst_new_sent", 64'(sent_count_o), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/axi_lite_write_sequencer.md
# axi_lite_write_sequencer

Buffers a stream of register-write commands and plays them, one at a time, into the write-command port of the AXI-Lite master core. It sits directly upstream of that core. It accepts address/data beats on an AXI-Stream slave, holds them in a small FIFO, and issues each one as a single-cycle write strobe. It paces itself on the core's `busy`, and counts completed and failed writes.

## Interface
Parameters:
- `AXI_DATA_WIDTH`, 32: data width of each write.
- `AXI_ADDR_WIDTH`, 32: address width of each write.
- `FIFO_DEPTH_LOG2`, 4: log2 of the command FIFO depth (16 entries).

Ports:
- `aclk`  in  1  single clock; all logic is on the rising edge.
- `aresetn`  in  1  asynchronous, active-low reset.
- `s_axis_tdata`  in  AXI_ADDR_WIDTH+AXI_DATA_WIDTH  command beat: [ADDR+DATA-1:DATA] = address, [DATA-1:0] = data.
- `s_axis_tvalid`  in  1  command beat valid.
- `s_axis_tready`  out  1  high when the FIFO is not full.
- `enable_i`  in  1  allows commands to leave the FIFO; when low, the block only buffers.
- `waddr_o`  out  AXI_ADDR_WIDTH  address to the master core.
- `wdata_o`  out  AXI_DATA_WIDTH  data to the master core.
- `wstrb_o`  out  AXI_DATA_WIDTH/8  write strobe; constant all ones.
- `write_o`  out  1  single-cycle write request to the master core.
- `busy_i`  in  1  busy flag from the master core.
- `write_failure_i`  in  1  failure flag from the master core; valid when `busy_i` falls.
- `fifo_count_o`  out  FIFO_DEPTH_LOG2+1  number of occupied FIFO entries, 0..2^FIFO_DEPTH_LOG2.
- `idle_o`  out  1  high when the FIFO is empty and the FSM is in IDLE.
- `sent_count_o`  out  32  number of completed writes; wraps modulo 2^32.
- `fail_count_o`  out  16  number of failed writes; saturates at 0xFFFF.

## Operation
- **FIFO:** synchronous, 2^FIFO_DEPTH_LOG2 entries, registered read.
  - Push when `s_axis_tvalid && s_axis_tready`; `s_axis_tready = !full`.
  - Push and pop in the same cycle: count is unchanged; the beat at the head is popped and the new beat is written.
  - When full, no push is possible. Pointers wrap modulo the depth.
- **FSM states:** IDLE, ISSUE, WAIT_START, WAIT_DONE.
  - IDLE → ISSUE when `!empty && enable_i && !busy_i`. On that edge: pop the FIFO head into `waddr_o`/`wdata_o`; `write_o` goes high for the following cycle.
  - ISSUE → WAIT_START unconditionally. `write_o` returns low.
  - WAIT_START → WAIT_DONE when `busy_i` is high.
  - WAIT_DONE → IDLE when `busy_i` is low. On that edge: `sent_count_o` += 1; if `write_failure_i` is high, `fail_count_o` += 1 (saturating).
- `waddr_o`/`wdata_o` are held constant from the pop until the next pop.
- Dropping `enable_i` never aborts a write already in flight; it only blocks the next IDLE → ISSUE transition.
- Reset asserted at any point, including mid-write, returns the block to the reset state immediately (asynchronous). Any buffered beats are discarded.
- `idle_o` = (state == IDLE) && empty.

## Timing
- **Reset values:**
  - `s_axis_tready` = 1 (FIFO empty).
  - `write_o` = 0.
  - `waddr_o`, `wdata_o` = 0; `wstrb_o` = all ones.
  - `fifo_count_o` = 0; `idle_o` = 1.
  - `sent_count_o` = 0; `fail_count_o` = 0.
  - FSM in IDLE.
- **Latency:** a beat accepted at edge n into an empty FIFO with the FSM in IDLE is popped at edge n+1. `write_o` is high in the cycle from edge n+1 to edge n+2.
- `write_o` is never high for two consecutive cycles.
- `write_o` is never asserted while `busy_i` was high at the deciding edge.
- **Minimum spacing** between `write_o` pulses is 4 cycles (ISSUE, WAIT_START, at least 1 WAIT_DONE, IDLE). Back-to-back throughput depends on the master's busy time.
- `fifo_count_o` updates on the edge after the push or pop.
- `s_axis_tready` falls in the same cycle `fifo_count_o` reaches 2^FIFO_DEPTH_LOG2.
- Counter updates are visible in the cycle after the WAIT_DONE → IDLE edge.

## Test plan
- **Single write:** push {0x4000_0010, 0xDEAD_BEEF}; model busy_i high for 3 cycles starting 1 cycle after write_o. Required: one write_o pulse with waddr_o=0x4000_0010, wdata_o=0xDEAD_BEEF, wstrb_o=0xF; then sent_count_o=1, fail_count_o=0, idle_o=1.
- **Fill with enable_i low:** push 17 beats with enable_i=0. Required: the first 16 are accepted; fifo_count_o=16; s_axis_tready=0 on the 17th beat; no write_o pulse.
- **Drain:** after the fill scenario, raise enable_i. Required: 16 write_o pulses in FIFO order; no pulse while busy_i is high; sent_count_o=16; fifo_count_o=0.
- **Failure counting:** three writes, with write_failure_i=1 when busy_i falls on the 2nd write. Required: fail_count_o=1, sent_count_o=3. Separately, preload fail_count_o to 0xFFFF via 65535 failures and add one more failure: the count stays at 0xFFFF.
- **Simultaneous push/pop at full:** with the FIFO at 15 entries, push one beat and pop the head in the same cycle. Required: fifo_count_o stays 15, then the next push reaches 16; data order is preserved.
- **Reset mid-write:** assert aresetn=0 during WAIT_DONE with 5 entries buffered. Required: all outputs take their reset values in the same cycle; after release, a new beat is written with no stale write_o.
